pulse_scheduler: RTL and testbench

PULSE_SCHEDULER -- requirements
Module: pulse_scheduler

---
 rtl/pulse_scheduler.sv | 133 +++++++++++++
 tb/tb_pulse_scheduler.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : pulse_scheduler
// Purpose  : NCH periodic channels whose expiries are serialised into a single
//            registered pulse stream by a round-robin arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module pulse_scheduler #(
    parameter int NCH  = 4,
    parameter int SIZE = 8,
    parameter int IDW  = $clog2(NCH)
) (
    input  logic            clk_i,
    input  logic            nrst_i,
    input  logic            en_i,
    input  logic            cfg_we_i,
    input  logic [IDW-1:0]  cfg_ch_i,
    input  logic [SIZE-1:0] cfg_period_i,
    input  logic            cfg_en_i,
    input  logic            ovr_clr_i,
    output logic            pulse_o,
    output logic [IDW-1:0]  pulse_ch_o,
    output logic [NCH-1:0]  pending_o,
    output logic [NCH-1:0]  overrun_o
);

    localparam logic [IDW:0]   c_NCH     = (IDW+1)'(NCH);
    localparam logic [IDW-1:0] c_PTR_RST = IDW'(NCH - 1);

    logic            w_cfg_hit;
    logic [NCH-1:0]  w_wr;
    logic [NCH-1:0]  w_exp;
    logic [NCH-1:0]  w_cand;
    logic [NCH-1:0]  w_pending_nxt;
    logic [NCH-1:0]  w_ovr_set;
    logic            w_gnt_vld;
    logic [IDW-1:0]  w_gnt_idx;
    logic [IDW-1:0]  w_scan_idx;

    logic [NCH-1:0]  r_pending;
    logic [NCH-1:0]  r_overrun;
    logic [IDW-1:0]  r_ptr;
    logic            r_pulse;
    logic [IDW-1:0]  r_pulse_ch;

    // Out-of-range indices (non-power-of-two NCH) must not alias a real channel.
    assign w_cfg_hit = cfg_we_i && ({1'b0, cfg_ch_i} < c_NCH);

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic [SIZE-1:0] r_period;
        logic [SIZE-1:0] r_cnt;
        logic            r_ch_en;

        assign w_wr[g]  = w_cfg_hit && (cfg_ch_i == IDW'(g));
        assign w_exp[g] = en_i && r_ch_en && (r_cnt == r_period);

        always_ff @(posedge clk_i or negedge nrst_i) begin
            if (!nrst_i) begin
                r_period <= '0;
                r_cnt    <= '0;
                r_ch_en  <= 1'b0;
            end else if (w_wr[g]) begin
                r_period <= cfg_period_i;
                r_cnt    <= '0;
                r_ch_en  <= cfg_en_i;
            end else if (en_i && r_ch_en) begin
                r_cnt <= w_exp[g] ? '0 : r_cnt + SIZE'(1);
            end
        end
    end

    // A channel being reconfigured is withheld from arbitration this cycle.
    assign w_cand = en_i ? (r_pending & ~w_wr) : '0;

    // Scan from farthest offset down so the nearest candidate after r_ptr wins.
    always_comb begin
        w_gnt_vld  = 1'b0;
        w_gnt_idx  = r_ptr;
        w_scan_idx = '0;
        for (int k = NCH; k >= 1; k--) begin
            w_scan_idx = IDW'((int'(r_ptr) + k) % NCH);
            if (w_cand[w_scan_idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_scan_idx;
            end
        end
    end

    always_comb begin
        w_pending_nxt = r_pending;
        w_ovr_set     = '0;
        for (int i = 0; i < NCH; i++) begin
            if (w_wr[i]) begin
                w_pending_nxt[i] = 1'b0;
            end else begin
                if (w_gnt_vld && (w_gnt_idx == IDW'(i))) begin
                    w_pending_nxt[i] = 1'b0;
                end
                if (w_exp[i]) begin
                    w_pending_nxt[i] = 1'b1;
                    if (r_pending[i] && !(w_gnt_vld && (w_gnt_idx == IDW'(i)))) begin
                        w_ovr_set[i] = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            r_pending  <= '0;
            r_overrun  <= '0;
            r_ptr      <= c_PTR_RST;
            r_pulse    <= 1'b0;
            r_pulse_ch <= '0;
        end else begin
            r_pending <= w_pending_nxt;
            r_overrun <= (r_overrun & ~{NCH{ovr_clr_i}}) | w_ovr_set;
            r_pulse   <= w_gnt_vld;
            if (w_gnt_vld) begin
                r_pulse_ch <= w_gnt_idx;
                r_ptr      <= w_gnt_idx;
            end
        end
    end

    assign pulse_o    = r_pulse;
    assign pulse_ch_o = r_pulse_ch;
    assign pending_o  = r_pending;
    assign overrun_o  = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_pulse_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_pulse_scheduler
// Purpose  : Vector table, directed corner sequences and randomized traffic
//            checked against a cycle-count reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pulse_scheduler;

    localparam int NCH  = 4;
    localparam int SIZE = 8;
    localparam int IDW  = 2;

    logic            clk_i = 1'b0;
    logic            nrst_i;
    logic            en_i;
    logic            cfg_we_i;
    logic [IDW-1:0]  cfg_ch_i;
    logic [SIZE-1:0] cfg_period_i;
    logic            cfg_en_i;
    logic            ovr_clr_i;
    logic            pulse_o;
    logic [IDW-1:0]  pulse_ch_o;
    logic [NCH-1:0]  pending_o;
    logic [NCH-1:0]  overrun_o;

    logic            s3_we;
    logic [1:0]      s3_ch;
    logic [SIZE-1:0] s3_period;
    logic            s3_cfg_en;
    logic            s3_pulse;
    logic [1:0]      s3_pulse_ch;
    logic [2:0]      s3_pend;
    logic [2:0]      s3_ovr;

    int n_vec = 0;
    int n_err = 0;

    pulse_scheduler #(.NCH(NCH), .SIZE(SIZE), .IDW(IDW)) u_dut (
        .clk_i(clk_i), .nrst_i(nrst_i), .en_i(en_i),
        .cfg_we_i(cfg_we_i), .cfg_ch_i(cfg_ch_i), .cfg_period_i(cfg_period_i),
        .cfg_en_i(cfg_en_i), .ovr_clr_i(ovr_clr_i),
        .pulse_o(pulse_o), .pulse_ch_o(pulse_ch_o),
        .pending_o(pending_o), .overrun_o(overrun_o)
    );

    pulse_scheduler #(.NCH(3), .SIZE(SIZE), .IDW(2)) u_dut3 (
        .clk_i(clk_i), .nrst_i(nrst_i), .en_i(en_i),
        .cfg_we_i(s3_we), .cfg_ch_i(s3_ch), .cfg_period_i(s3_period),
        .cfg_en_i(s3_cfg_en), .ovr_clr_i(ovr_clr_i),
        .pulse_o(s3_pulse), .pulse_ch_o(s3_pulse_ch),
        .pending_o(s3_pend), .overrun_o(s3_ovr)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: a channel expires whenever its count of enabled cycles
    // since configuration t satisfies t mod (P+1) == P.
    int             m_p   [NCH];
    bit             m_en  [NCH];
    int             m_t   [NCH];
    bit [NCH-1:0]   m_pend;
    bit [NCH-1:0]   m_ovr;
    int             m_last;
    bit             m_pulse;
    int             m_pulse_ch;

    function automatic void model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_p[i] = 0; m_en[i] = 1'b0; m_t[i] = 0;
        end
        m_pend = '0; m_ovr = '0; m_last = NCH - 1;
        m_pulse = 1'b0; m_pulse_ch = 0;
    endfunction

    function automatic void model_step(bit en, bit we, int ch, int per, bit cen, bit clr);
        bit [NCH-1:0] ex;
        bit [NCH-1:0] nxt;
        bit [NCH-1:0] set;
        bit gv;
        int gi;
        gv = 1'b0; gi = 0; set = '0;
        for (int i = 0; i < NCH; i++)
            ex[i] = en && m_en[i] && ((m_t[i] % (m_p[i] + 1)) == m_p[i]);
        if (en) begin
            for (int k = 1; k <= NCH; k++) begin
                int j;
                j = (m_last + k) % NCH;
                if (!gv && m_pend[j] && !(we && ch == j)) begin
                    gv = 1'b1; gi = j;
                end
            end
        end
        nxt = m_pend;
        for (int i = 0; i < NCH; i++) begin
            if (we && ch == i) nxt[i] = 1'b0;
            else if (ex[i]) begin
                if (m_pend[i] && !(gv && gi == i)) set[i] = 1'b1;
                nxt[i] = 1'b1;
            end else if (gv && gi == i) nxt[i] = 1'b0;
        end
        m_ovr  = (clr ? '0 : m_ovr) | set;
        m_pend = nxt;
        m_pulse = gv;
        if (gv) begin
            m_pulse_ch = gi; m_last = gi;
        end
        for (int i = 0; i < NCH; i++) begin
            if (we && ch == i) begin
                m_p[i] = per; m_en[i] = cen; m_t[i] = 0;
            end else if (en && m_en[i]) m_t[i]++;
        end
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model(string tag);
        logic [IDW-1:0] ech;
        ech = IDW'(m_pulse_ch);
        check(tag, {21'd0, pulse_o, pulse_ch_o, pending_o, overrun_o},
                   {21'd0, m_pulse, ech, m_pend, m_ovr});
    endtask

    // Inputs are set by the caller before tick; the edge is then modelled and
    // outputs compared 1 time unit later.
    task automatic tick(string tag);
        bit en, we, cen, clr;
        int ch, per;
        en = en_i; we = cfg_we_i; cen = cfg_en_i; clr = ovr_clr_i;
        ch = int'(cfg_ch_i); per = int'(cfg_period_i);
        @(posedge clk_i);
        model_step(en, we, ch, per, cen, clr);
        #1;
        check_model(tag);
    endtask

    task automatic idle();
        cfg_we_i = 1'b0; ovr_clr_i = 1'b0;
        s3_we = 1'b0;
    endtask

    task automatic cfg(int ch, int per, bit cen);
        cfg_we_i = 1'b1; cfg_ch_i = IDW'(ch);
        cfg_period_i = SIZE'(per); cfg_en_i = cen;
    endtask

    task automatic do_reset();
        idle();
        en_i = 1'b0;
        nrst_i = 1'b0;
        #2;
        model_reset();
        check("reset_state", {21'd0, pulse_o, pulse_ch_o, pending_o, overrun_o}, 32'd0);
        check("reset_state3", {24'd0, s3_pulse, s3_pulse_ch, s3_pend, s3_ovr}, 32'd0);
        @(posedge clk_i);
        #1 nrst_i = 1'b1;
    endtask

    typedef struct {
        bit           en;
        bit           we;
        bit [1:0]     ch;
        bit [7:0]     per;
        bit           cen;
        bit           clr;
        bit           e_pulse;
        bit [1:0]     e_ch;
        bit [3:0]     e_pend;
        bit [3:0]     e_ovr;
    } vec_t;

    vec_t tbl [12];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        // Ch0 P=3: expiry every 4 edges, pulse one edge after each expiry.
        tbl[0]  = '{1'b1, 1'b1, 2'd0, 8'd3, 1'b1, 1'b0, 1'b0, 2'd0, 4'h0, 4'h0};
        tbl[1]  = '{1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 4'h0};
        tbl[2]  = '{1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 4'h0};
        tbl[3]  = '{1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 4'h0};
        tbl[4]  = '{1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0, 2'd0, 4'h1, 4'h0};
        tbl[5]  = '{1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 1'b1, 2'd0, 4'h0, 4'h0};
        tbl[6]  = '{1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 4'h0};
        tbl[7]  = '{1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 4'h0};
        tbl[8]  = '{1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0, 2'd0, 4'h1, 4'h0};
        tbl[9]  = '{1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 1'b1, 2'd0, 4'h0, 4'h0};
        tbl[10] = '{1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 4'h0};
        tbl[11] = '{1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 4'h0};

        cfg_ch_i = '0; cfg_period_i = '0; cfg_en_i = 1'b0;
        s3_ch = '0; s3_period = '0; s3_cfg_en = 1'b0;
        do_reset();

        for (int r = 0; r < 12; r++) begin
            en_i = tbl[r].en; cfg_we_i = tbl[r].we; cfg_ch_i = tbl[r].ch;
            cfg_period_i = tbl[r].per; cfg_en_i = tbl[r].cen; ovr_clr_i = tbl[r].clr;
            tick("tbl_model");
            check($sformatf("tbl_row%0d", r),
                  {21'd0, pulse_o, pulse_ch_o, pending_o, overrun_o},
                  {21'd0, tbl[r].e_pulse, tbl[r].e_ch, tbl[r].e_pend, tbl[r].e_ovr});
        end

        // All channels P=0: rotation 0,1,2,3,0 and overruns everywhere.
        do_reset();
        for (int c = 0; c < NCH; c++) begin
            cfg(c, 0, 1'b1);
            tick("p0_cfg");
        end
        idle();
        en_i = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            tick("p0_run");
            if (n >= 2)
                check($sformatf("p0_rotate%0d", n), {29'd0, pulse_o, pulse_ch_o},
                      {29'd0, 1'b1, 2'((n - 2) % 4)});
            if (n == 4) check("p0_ovr_all", {28'd0, overrun_o}, 32'hF);
        end
        ovr_clr_i = 1'b1;
        tick("p0_clr");
        ovr_clr_i = 1'b0;
        tick("p0_after_clr");
        check("p0_ovr_reset", {28'd0, overrun_o}, 32'hF);

        // Ch1 P=5 frozen by en_i low for 10 cycles mid-count.
        do_reset();
        en_i = 1'b1;
        cfg(1, 5, 1'b1);
        tick("frz_cfg");
        idle();
        repeat (3) tick("frz_pre");
        en_i = 1'b0;
        repeat (10) tick("frz_hold");
        en_i = 1'b1;
        first = -1;
        for (int n = 1; n <= 20 && first < 0; n++) begin
            tick("frz_resume");
            if (pulse_o) first = n;
        end
        check("frz_first_pulse", 32'(first), 32'd4);

        // Ch2 expiry coincident with a reconfiguration to P=7.
        do_reset();
        en_i = 1'b1;
        cfg(2, 2, 1'b1);
        tick("coin_cfg");
        idle();
        repeat (2) tick("coin_pre");
        cfg(2, 7, 1'b1);
        tick("coin_write");
        check("coin_pend2", {31'd0, pending_o[2]}, 32'd0);
        idle();
        first = -1;
        for (int n = 1; n <= 30 && first < 0; n++) begin
            tick("coin_run");
            if (pulse_o) first = n;
        end
        check("coin_next_pulse", 32'(first), 32'd9);

        // NCH=3 build: index 3 is out of range and must be ignored.
        do_reset();
        en_i = 1'b1;
        s3_we = 1'b1; s3_ch = 2'd3; s3_period = '0; s3_cfg_en = 1'b1;
        tick("n3_bad_wr");
        s3_we = 1'b0;
        repeat (4) tick("n3_idle");
        check("n3_ignore", {24'd0, s3_pulse, s3_pulse_ch, s3_pend, s3_ovr}, 32'd0);
        s3_we = 1'b1; s3_ch = 2'd2;
        tick("n3_good_wr");
        s3_we = 1'b0;
        tick("n3_exp");
        check("n3_pend", {29'd0, s3_pend}, 32'h4);
        tick("n3_grant");
        check("n3_pulse", {29'd0, s3_pulse, s3_pulse_ch}, {29'd0, 1'b1, 2'd2});

        // Asynchronous reset with pending = 1010.
        do_reset();
        cfg(1, 0, 1'b1);
        tick("ar_cfg1");
        cfg(3, 0, 1'b1);
        tick("ar_cfg3");
        idle();
        en_i = 1'b1;
        tick("ar_exp");
        check("ar_pend", {28'd0, pending_o}, 32'hA);
        #3 nrst_i = 1'b0;
        #1;
        check("ar_async", {21'd0, pulse_o, pulse_ch_o, pending_o, overrun_o}, 32'd0);
        model_reset();
        @(posedge clk_i);
        #1 nrst_i = 1'b1;
        for (int n = 0; n < 10; n++) begin
            tick("ar_post");
            check("ar_no_pulse", {31'd0, pulse_o}, 32'd0);
        end

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            en_i         = ($urandom_range(0, 9) != 0);
            cfg_we_i     = ($urandom_range(0, 15) == 0);
            cfg_ch_i     = IDW'($urandom_range(0, NCH - 1));
            cfg_period_i = SIZE'($urandom_range(0, 12));
            cfg_en_i     = ($urandom_range(0, 4) != 0);
            ovr_clr_i    = ($urandom_range(0, 31) == 0);
            tick("rnd");
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
